axi_tagctrl_way_rd_unit: RTL and testbench

Request-side initiator for one tag-controller data way. It accepts a burst read descriptor, issues one single-beat read request per beat to the data way, and collects the 1-cycle-latency way responses in a credit-limited buffer. It returns the responses as an in-order beat stream with a last flag. It sits between the read-path control of the tag controller and the data way.

---
 rtl/axi_tagctrl_way_rd_unit.sv | 124 ++++++++++++
 tb/tb_axi_tagctrl_way_rd_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_tagctrl_way_rd_unit.sv
// axi_tagctrl_way_rd_unit: splits a burst read descriptor into single-beat data-way reads and returns the beats in order
// Ports: desc_* burst descriptor in; way_req_* / way_rsp_* data-way request and response; r_* in-order beat stream
// with last flag; busy_o burst in progress; err_o sticky tag/unsolicited-response error.
// Option: AXI_TAGCTRL_RD_UNIT_TAG_CHECK_EN enables the response tag check that drives err_o.
module axi_tagctrl_way_rd_unit #(
  parameter int IndexLength       = 8,
  parameter int BlockOffsetLength = 3,
  parameter int DataWidth         = 64,
  parameter int NumWays           = 8,
  parameter int UnitWidth         = 2,
  parameter int UnitId            = 1,
  parameter int Depth             = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         desc_valid_i,
  output logic                         desc_ready_o,
  input  logic [NumWays-1:0]           desc_way_i,
  input  logic [IndexLength-1:0]       desc_line_i,
  input  logic [BlockOffsetLength-1:0] desc_offset_i,
  input  logic [BlockOffsetLength-1:0] desc_len_i,
  output logic                         way_req_valid_o,
  input  logic                         way_req_ready_i,
  output logic [UnitWidth-1:0]         way_req_unit_o,
  output logic [NumWays-1:0]           way_req_way_o,
  output logic [IndexLength-1:0]       way_req_line_o,
  output logic [BlockOffsetLength-1:0] way_req_offset_o,
  output logic                         way_req_we_o,
  input  logic                         way_rsp_valid_i,
  output logic                         way_rsp_ready_o,
  input  logic [UnitWidth-1:0]         way_rsp_unit_i,
  input  logic [DataWidth-1:0]         way_rsp_data_i,
  output logic                         r_valid_o,
  input  logic                         r_ready_i,
  output logic [DataWidth-1:0]         r_data_o,
  output logic                         r_last_o,
  output logic                         busy_o,
  output logic                         err_o
);
  localparam int CW = $clog2(Depth + 1);
  localparam int PW = Depth > 1 ? $clog2(Depth) : 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(Depth);
  localparam logic [PW-1:0] LAST_PTR = PW'(Depth - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state_q, state_d;
  logic [NumWays-1:0] way_q;
  logic [IndexLength-1:0] line_q;
  logic [BlockOffsetLength-1:0] offset_q, issue_cnt, beat_cnt;
  logic [CW-1:0] outst, fill;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [DataWidth-1:0] mem [Depth];
  logic desc_hs, req_hs, push, pop;
  assign desc_ready_o = state_q == IDLE;
  assign busy_o = state_q != IDLE;
  // Credit check: in-flight reads plus buffered beats must leave room for one more response.
  assign way_req_valid_o = state_q == ISSUE && ({1'b0, outst} + {1'b0, fill}) < DEPTH_W;
  assign way_req_unit_o = UnitWidth'(UnitId);
  assign way_req_way_o = way_q;
  assign way_req_line_o = line_q;
  assign way_req_offset_o = offset_q;
  assign way_req_we_o = 1'b0;
  assign way_rsp_ready_o = 1'b1;
  assign desc_hs = desc_valid_i && desc_ready_o;
  assign req_hs = way_req_valid_o && way_req_ready_i;
  // A response with nothing in flight is unsolicited and dropped.
  assign push = way_rsp_valid_i && outst != '0;
  assign pop = r_valid_o && r_ready_i;
  assign r_valid_o = fill != '0;
  assign r_data_o = mem[rd_ptr];
  assign r_last_o = r_valid_o && beat_cnt == '0;
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && desc_hs) state_d = ISSUE;
    if (state_q == ISSUE && req_hs && issue_cnt == '0) state_d = DRAIN;
    if (state_q == DRAIN && pop && beat_cnt == '0) state_d = IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      way_q <= '0;
      line_q <= '0;
      offset_q <= '0;
      issue_cnt <= '0;
      beat_cnt <= '0;
      outst <= '0;
      fill <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state_q <= state_d;
      if (desc_hs) begin
        way_q <= desc_way_i;
        line_q <= desc_line_i;
        offset_q <= desc_offset_i;
        issue_cnt <= desc_len_i;
        beat_cnt <= desc_len_i;
      end
      if (req_hs) begin
        offset_q <= offset_q + 1'b1;
        issue_cnt <= issue_cnt - 1'b1;
      end
      if (pop) beat_cnt <= beat_cnt - 1'b1;
      outst <= outst + CW'(req_hs) - CW'(push);
      fill <= fill + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr == LAST_PTR ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr == LAST_PTR ? '0 : rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= way_rsp_data_i;
  end
`ifdef AXI_TAGCTRL_RD_UNIT_TAG_CHECK_EN
  logic err_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else if (way_rsp_valid_i && (way_rsp_unit_i != UnitWidth'(UnitId) || outst == '0)) err_q <= 1'b1;
  end
  assign err_o = err_q;
`else
  logic unused_rsp_unit;
  assign unused_rsp_unit = ^way_rsp_unit_i;
  assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_axi_tagctrl_way_rd_unit.sv
// tb_axi_tagctrl_way_rd_unit: scoreboard bench with a data-way responder and an r-stream monitor
module tb_axi_tagctrl_way_rd_unit;
  localparam int IL = 8, BL = 3, DW = 64, NW = 8, UW = 2, UID = 1, DEP = 2;
`ifdef AXI_TAGCTRL_RD_UNIT_TAG_CHECK_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif
  logic clk, rst_i;
  logic desc_valid_i, desc_ready_o;
  logic [NW-1:0] desc_way_i, way_req_way_o;
  logic [IL-1:0] desc_line_i, way_req_line_o;
  logic [BL-1:0] desc_offset_i, desc_len_i, way_req_offset_o;
  logic way_req_valid_o, way_req_ready_i, way_req_we_o;
  logic [UW-1:0] way_req_unit_o, way_rsp_unit_i;
  logic way_rsp_valid_i, way_rsp_ready_o;
  logic [DW-1:0] way_rsp_data_i, r_data_o;
  logic r_valid_o, r_ready_i, r_last_o, busy_o, err_o;

  axi_tagctrl_way_rd_unit #(
    .IndexLength(IL), .BlockOffsetLength(BL), .DataWidth(DW), .NumWays(NW),
    .UnitWidth(UW), .UnitId(UID), .Depth(DEP)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o), .desc_way_i(desc_way_i),
    .desc_line_i(desc_line_i), .desc_offset_i(desc_offset_i), .desc_len_i(desc_len_i),
    .way_req_valid_o(way_req_valid_o), .way_req_ready_i(way_req_ready_i), .way_req_unit_o(way_req_unit_o),
    .way_req_way_o(way_req_way_o), .way_req_line_o(way_req_line_o), .way_req_offset_o(way_req_offset_o),
    .way_req_we_o(way_req_we_o), .way_rsp_valid_i(way_rsp_valid_i), .way_rsp_ready_o(way_rsp_ready_o),
    .way_rsp_unit_i(way_rsp_unit_i), .way_rsp_data_i(way_rsp_data_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o), .r_last_o(r_last_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {logic [NW-1:0] w; logic [IL-1:0] l; logic [BL-1:0] o;} req_t;
  typedef struct packed {logic [DW-1:0] d; logic last;} beat_t;
  req_t exp_req[$];
  beat_t exp_beat[$];
  int total = 0, passed = 0, req_count = 0, beats_seen = 0;
  bit r_rand = 0, w_rand = 0, way_stall = 0, bad_tag = 0, inj = 0, r_hold = 1;
  logic [31:0] salt;

  function automatic logic [DW-1:0] beat_data(input logic [NW-1:0] w, input logic [IL-1:0] l, input logic [BL-1:0] o);
    return {salt, w, l, 13'd0, o};
  endfunction

  task automatic chk(input bit ok, input string name, input logic [DW:0] act, input logic [DW:0] exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_reset(input string tag);
    chk(desc_ready_o == 1'b1, {tag, "_desc_ready"}, desc_ready_o, 1);
    chk(way_rsp_ready_o == 1'b1, {tag, "_rsp_ready"}, way_rsp_ready_o, 1);
    chk(way_req_valid_o == 1'b0, {tag, "_req_valid"}, way_req_valid_o, 0);
    chk(r_valid_o == 1'b0, {tag, "_r_valid"}, r_valid_o, 0);
    chk(r_last_o == 1'b0, {tag, "_r_last"}, r_last_o, 0);
    chk(busy_o == 1'b0, {tag, "_busy"}, busy_o, 0);
    chk(err_o == 1'b0, {tag, "_err"}, err_o, 0);
    chk(way_req_unit_o == UW'(UID), {tag, "_unit"}, way_req_unit_o, UID);
    chk(way_req_we_o == 1'b0, {tag, "_we"}, way_req_we_o, 0);
  endtask

  // Reference: a burst of len+1 beats reads offsets off, off+1, ... wrapping within the line.
  task automatic send_desc(input logic [NW-1:0] w, input logic [IL-1:0] l, input logic [BL-1:0] o, input logic [BL-1:0] n);
    bit got = 0;
    @(posedge clk); #1;
    desc_valid_i = 1'b1; desc_way_i = w; desc_line_i = l; desc_offset_i = o; desc_len_i = n;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      got = desc_ready_o;
      if (got)
        for (int b = 0; b <= int'(n); b++) begin
          logic [BL-1:0] ob;
          ob = o + BL'(b);
          exp_req.push_back('{w, l, ob});
          exp_beat.push_back('{beat_data(w, l, ob), b == int'(n)});
        end
      @(posedge clk); #1;
    end
    desc_valid_i = 1'b0;
    if (!got) chk(1'b0, "desc_timeout", 0, 1);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy_o && exp_beat.size() == 0 && exp_req.size() == 0) return;
    end
    chk(1'b0, {"idle_timeout_", name}, busy_o, 0);
  endtask

  // Data-way model: accepts requests, answers one cycle later, checks request order and stability.
  initial begin
    bit hs, pv;
    req_t cur, pp, e;
    logic [DW-1:0] d;
    pv = 0; d = '0;
    way_req_ready_i = 1'b1; way_rsp_valid_i = 1'b0; way_rsp_unit_i = UW'(UID); way_rsp_data_i = '0; r_ready_i = 1'b1;
    forever begin
      @(negedge clk);
      cur = '{way_req_way_o, way_req_line_o, way_req_offset_o};
      if (pv) chk(way_req_valid_o && cur == pp, "req_stable", {way_req_valid_o, cur}, {1'b1, pp});
      hs = way_req_valid_o && way_req_ready_i && !rst_i;
      pv = way_req_valid_o && !way_req_ready_i && !rst_i;
      pp = cur;
      if (hs) begin
        req_count++;
        if (exp_req.size() == 0) chk(1'b0, "req_unexpected", cur, 0);
        else begin
          e = exp_req.pop_front();
          chk(cur == e && way_req_unit_o == UW'(UID) && !way_req_we_o, "req_payload",
              {way_req_unit_o, way_req_we_o, cur}, {UW'(UID), 1'b0, e});
        end
        d = beat_data(cur.w, cur.l, cur.o);
      end
      @(posedge clk); #1;
      way_rsp_valid_i = hs || inj;
      way_rsp_data_i = hs ? d : {$urandom, $urandom};
      way_rsp_unit_i = bad_tag ? '0 : UW'(UID);
      inj = 0;
      way_req_ready_i = !way_stall && (!w_rand || $urandom_range(0, 3) != 0);
      r_ready_i = r_rand ? 1'($urandom_range(0, 1)) : r_hold;
    end
  end

  // Beat monitor: pops the scoreboard on every r handshake.
  initial begin
    bit pv;
    beat_t cur, pb, e;
    pv = 0;
    forever begin
      @(negedge clk);
      cur = '{r_data_o, r_last_o};
      if (pv) chk(r_valid_o && cur == pb, "r_stable", {r_valid_o, cur}, {1'b1, pb});
      pv = r_valid_o && !r_ready_i && !rst_i;
      pb = cur;
      if (r_valid_o && r_ready_i && !rst_i) begin
        beats_seen++;
        if (exp_beat.size() == 0) chk(1'b0, "beat_unexpected", cur, 0);
        else begin
          e = exp_beat.pop_front();
          chk(cur == e, "beat", cur, e);
        end
      end
    end
  end

  initial begin
    int base;
    rst_i = 1'b1; desc_valid_i = 1'b0; desc_way_i = '0; desc_line_i = '0; desc_offset_i = '0; desc_len_i = '0;
    salt = $urandom;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk_reset("rst");
    send_desc(8'h04, 8'h3c, 3'd5, 3'd0);
    @(negedge clk);
    chk(way_req_valid_o == 1'b1, "lat_req_c1", way_req_valid_o, 1);
    @(negedge clk);
    chk(r_valid_o == 1'b0, "lat_rvalid_c2", r_valid_o, 0);
    @(negedge clk);
    chk(r_valid_o && r_last_o, "lat_rvalid_c3", {r_valid_o, r_last_o}, 2'b11);
    wait_idle("single");
    chk(busy_o == 1'b0, "single_busy", busy_o, 0);
    send_desc(8'h01, 8'h10, 3'd6, 3'd3);
    wait_idle("wrap");
    r_hold = 0;
    base = req_count;
    send_desc(8'h02, 8'h22, 3'd0, 3'd7);
    repeat (10) @(negedge clk);
    chk(req_count - base == DEP, "bp_req_count", req_count - base, DEP);
    chk(way_req_valid_o == 1'b0, "bp_req_valid", way_req_valid_o, 0);
    r_hold = 1;
    wait_idle("backpressure");
    way_stall = 1;
    base = req_count;
    send_desc(8'h08, 8'h55, 3'd2, 3'd3);
    repeat (4) @(negedge clk);
    chk(req_count == base, "stall_no_req", req_count - base, 0);
    chk(way_req_valid_o && way_req_offset_o == 3'd2, "stall_hold", {way_req_valid_o, way_req_offset_o}, {1'b1, 3'd2});
    way_stall = 0;
    wait_idle("stall");
    r_rand = 1; w_rand = 1;
    repeat (25) send_desc(NW'(1) << $urandom_range(0, NW - 1), IL'($urandom), BL'($urandom), BL'($urandom));
    r_rand = 0; w_rand = 0;
    wait_idle("random");
    bad_tag = 1;
    send_desc(8'h10, 8'h77, 3'd1, 3'd1);
    wait_idle("tag");
    bad_tag = 0;
    chk(err_o == TAG_EN, "err_tag", err_o, TAG_EN);
    send_desc(8'h10, 8'h78, 3'd4, 3'd2);
    wait_idle("tag_sticky");
    chk(err_o == TAG_EN, "err_sticky", err_o, TAG_EN);
    base = beats_seen;
    send_desc(8'h20, 8'h99, 3'd0, 3'd7);
    for (int i = 0; i < 500 && beats_seen < base + 2; i++) @(negedge clk);
    chk(beats_seen >= base + 2, "mid_beats", beats_seen - base, 2);
    @(posedge clk); #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    exp_req.delete();
    exp_beat.delete();
    @(negedge clk);
    chk_reset("mid");
    inj = 1;
    repeat (4) begin
      @(negedge clk);
      chk(r_valid_o == 1'b0, "late_drop", r_valid_o, 0);
    end
    chk(err_o == TAG_EN, "err_unsol", err_o, TAG_EN);
    send_desc(8'h40, 8'h01, 3'd7, 3'd2);
    wait_idle("after_reset");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
